encode12: RTL and testbench
===========================

Name: encode12

Overview:
Packs pairs of 12-bit polynomial coefficients into a byte stream: 2 coefficients become 3 bytes, per Kyber poly_tobytes.
- This is the transmit-side counterpart of the coefficient byte decoder. It serialises public-key and ciphertext polynomials for output.
- It optionally maps signed coefficients in [-Q, Q-1] to canonical [0, Q-1] before packing.
- It sits between the polynomial arithmetic / NTT output and the byte-wide key/ciphertext output path.

Parameters:
N_PAIRS, 128, coefficient pairs per polynomial (KYBER_N/2); byte count per polynomial = 3*N_PAIRS.
Q, 3329, modulus used for canonicalisation and the range check.
CANON, 1, when 1 a negative input (bit 15 set) has Q added before packing; when 0 the input is used as-is.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
set  input  1  block enable; when 0 the block is frozen.
in_valid  input  1  a coefficient pair is presented.
in_ready  output  1  the block accepts the pair on this edge.
din_1  input  16  coefficient 2i, two's complement.
din_2  input  16  coefficient 2i+1, two's complement.
dout  output  8  packed byte.
out_valid  output  1  dout is valid.
out_ready  input  1  downstream accepts dout on this edge.
out_index  output  16  byte index (0..3*N_PAIRS-1) of the byte currently on dout.
poly_done  output  1  one-cycle pulse after the last byte of a polynomial transfers.
err_range  output  1  sticky flag: a canonicalised coefficient was >= Q.

Behaviour:
- Reset values: dout=0, out_valid=0, out_index=0, poly_done=0, err_range=0, state=EMPTY, pair buffer cleared. While reset is high, in_ready=0.
- Transfer definitions: in_xfer = set & in_valid & in_ready; out_xfer = set & out_valid & out_ready.
- Gating when set=0:
  - in_ready=0 and out_valid=0.
  - All registers hold; dout keeps its registered value internally but the port reads 0 while out_valid=0.
- Canonicalisation, per coefficient, on accept:
  - If CANON and c[15]=1, then c' = c + Q (16-bit); otherwise c' = c.
  - The packed value is c'[11:0].
  - If c' >= Q (unsigned 16-bit compare), set err_range; it stays set until reset.
  - The data is still packed as c'[11:0].
- The buffered pair (a, b) is registered on in_xfer.
- Byte mapping:
  - byte0 = a[7:0]
  - byte1 = {b[3:0], a[11:8]}
  - byte2 = b[11:4]
- FSM states: EMPTY, B0, B1, B2. out_valid=1 in B0/B1/B2, 0 in EMPTY.
  - EMPTY: in_xfer -> B0.
  - B0: out_xfer -> B1.
  - B1: out_xfer -> B2.
  - B2: out_xfer with simultaneous in_xfer -> B0 (new pair loaded); out_xfer without in_xfer -> EMPTY.
- in_ready = set & (state==EMPTY | (state==B2 & out_ready)). in_ready is combinational from state and out_ready only; it does not depend on in_valid.
- Latency: byte0 is valid the cycle after in_xfer.
- Throughput: 1 byte/cycle with no bubble between pairs when in_valid and out_ready are held high.
- Backpressure: while out_valid=1 and out_xfer=0, dout and out_index hold stable.
- out_index:
  - Increments on every out_xfer.
  - On the out_xfer of byte 3*N_PAIRS-1 it wraps to 0, and poly_done=1 for exactly the next cycle.
- Simultaneous in_xfer and out_xfer of byte2: the new pair overwrites the buffer on the same edge; no byte is lost or duplicated.
- Reset mid-operation: the buffered pair is discarded and the next accepted pair starts at byte0 with out_index=0.

Decomposition:
- Shared package kyber_pkg holds:
  - KYBER_Q=3329, KYBER_N=256, KYBER_POLYBYTES=384
  - the state encoding constants EMPTY/B0/B1/B2
- One combinational sub-module, canon12: input 16-bit coefficient; outputs 12-bit packed value and an out-of-range flag. It is instantiated twice, once per coefficient; CANON is passed through.
- The FSM, buffer, byte mux and index counter live in encode12.

Test Plan:
1. din_1=0x0123, din_2=0x0456, out_ready=1 -> bytes 0x23, 0x61, 0x45 on 3 consecutive cycles; out_index 0,1,2; in_ready high only in the EMPTY and B2 cycles.
2. CANON=1, din_1=0xFFFF (-1), din_2=0xF2FF (-3329) -> packed values 0xD00 and 0x000; bytes 0x00, 0x0D, 0x00; err_range=0.
3. 128 pairs with in_valid=1 and out_ready=1 throughout -> 384 bytes with no idle cycle; poly_done pulses once after byte 383; out_index returns to 0; the next pair starts at index 0.
4. Hold out_ready=0 for 5 cycles while in B1 of case 1 -> dout=0x61 and out_index=1 stable, in_ready=0; resuming yields 0x45 next.
5. din_1=0x0D01 (3329), din_2=0 -> err_range rises and stays 1 through later good pairs; byte0=0x01; err_range is cleared only by reset.
6. Assert reset after byte1 of a pair -> out_valid=0, out_index=0 immediately. Then apply set=0 with in_valid=1 -> no accept. With set=1, the next pair emits from byte0.

Source files
------------

// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber constants and the byte-encoder state encoding
package kyber_pkg;
  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int KYBER_POLYBYTES = 384;
  typedef enum logic [1:0] {EMPTY, B0, B1, B2} enc_state_t;
endpackage

// File: rtl/canon12.sv
// canon12: maps a signed coefficient to canonical form and flags values >= Q
module canon12
  import kyber_pkg::*;
#(
  parameter int Q     = KYBER_Q,
  parameter bit CANON = 1'b1
) (
  input  logic [15:0] coef,
  output logic [11:0] val,
  output logic        range_err
);
  logic [15:0] adj;
  assign adj       = (CANON && coef[15]) ? coef + 16'(Q) : coef;
  assign val       = adj[11:0];
  assign range_err = adj >= 16'(Q);
endmodule

// File: rtl/encode12.sv
// encode12: packs pairs of 12-bit coefficients into a 3-byte-per-pair stream
module encode12
  import kyber_pkg::*;
#(
  parameter int N_PAIRS = 128,
  parameter int Q       = KYBER_Q,
  parameter bit CANON   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] din_1,
  input  logic [15:0] din_2,
  output logic [7:0]  dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_index,
  output logic        poly_done,
  output logic        err_range
);
  localparam logic [15:0] LAST = 16'(3 * N_PAIRS - 1);
  enc_state_t  state, state_nxt;
  logic [11:0] a, b, ca, cb;
  logic        ea, eb, in_xfer, out_xfer;
  canon12 #(.Q(Q), .CANON(CANON)) u_c1 (.coef(din_1), .val(ca), .range_err(ea));
  canon12 #(.Q(Q), .CANON(CANON)) u_c2 (.coef(din_2), .val(cb), .range_err(eb));
  assign in_ready  = set & ~reset & (state == EMPTY | (state == B2 & out_ready));
  assign out_valid = set & (state != EMPTY);
  assign in_xfer   = set & in_valid & in_ready;
  assign out_xfer  = set & out_valid & out_ready;
  assign dout = !out_valid     ? 8'h00 :
                (state == B0)  ? a[7:0] :
                (state == B1)  ? {b[3:0], a[11:8]} : b[11:4];
  // next state: walk B0->B1->B2 per accepted byte; B2 reloads when a pair arrives alongside
  always_comb begin
    state_nxt = (state == EMPTY) ? (in_xfer ? B0 : EMPTY) :
                !out_xfer        ? state :
                (state == B0)    ? B1 :
                (state == B1)    ? B2 :
                in_xfer          ? B0 : EMPTY;
  end
  // state, pair buffer, byte index, completion pulse and sticky range flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      a         <= '0;
      b         <= '0;
      out_index <= '0;
      poly_done <= 1'b0;
      err_range <= 1'b0;
    end else begin
      state     <= state_nxt;
      poly_done <= out_xfer & (out_index == LAST);
      if (in_xfer) begin
        a <= ca;
        b <= cb;
      end
      if (in_xfer & (ea | eb)) err_range <= 1'b1;
      if (out_xfer) out_index <= (out_index == LAST) ? 16'd0 : out_index + 16'd1;
    end
  end
endmodule

// File: tb/tb_encode12.sv
// tb_encode12: randomized and directed checks of encode12 against a byte-queue model
module tb_encode12;
  logic        clk = 1'b0, reset, set, in_valid, out_ready;
  logic [15:0] din_1, din_2;
  logic        in_ready, out_valid, poly_done, err_range;
  logic [7:0]  dout;
  logic [15:0] out_index;
  int nvec = 0, nerr = 0;
  int q[$];
  int m_idx, m_done, m_err;

  encode12 dut (.clk(clk), .reset(reset), .set(set), .in_valid(in_valid), .in_ready(in_ready),
                .din_1(din_1), .din_2(din_2), .dout(dout), .out_valid(out_valid),
                .out_ready(out_ready), .out_index(out_index), .poly_done(poly_done),
                .err_range(err_range));

  always #5 clk = ~clk;

  // reference canonicalisation with integer arithmetic
  function automatic int canon(input logic [15:0] c, output bit e);
    int v;
    v = int'($signed(c));
    if (v < 0) v += 3329;
    if (v < 0) v += 65536;
    e = (v >= 3329);
    return v % 4096;
  endfunction

  function automatic bit exp_in_ready();
    return set && !reset && (q.size() == 0 || (q.size() == 1 && out_ready));
  endfunction

  function automatic bit exp_out_valid();
    return set && q.size() > 0;
  endfunction

  function automatic int exp_dout();
    return exp_out_valid() ? q[0] : 0;
  endfunction

  // advance one clock, updating the model from the current inputs
  task automatic tick();
    bit ix, ox, ea, eb;
    int w;
    ix = exp_in_ready() && in_valid;
    ox = exp_out_valid() && out_ready;
    m_done = 0;
    if (ox) begin
      void'(q.pop_front());
      if (m_idx == 383) begin m_idx = 0; m_done = 1; end else m_idx++;
    end
    if (ix) begin
      w = canon(din_1, ea) | (canon(din_2, eb) << 12);
      q.push_back(w & 255);
      q.push_back((w >> 8) & 255);
      q.push_back((w >> 16) & 255);
      if (ea || eb) m_err = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    m_idx = 0; m_done = 0; m_err = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [15:0] rand_coef();
    case ($urandom_range(0, 3))
      0: return 16'($urandom_range(0, 3328));
      1: return 16'(-$urandom_range(1, 3329));
      2: return 16'($urandom);
      default: return 16'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; set = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    din_1 = 16'h0123; din_2 = 16'h0456;
    q.delete(); m_idx = 0; m_done = 0; m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || dout !== 8'h00 || out_index !== 16'd0 ||
        poly_done !== 1'b0 || err_range !== 1'b0) begin
      nerr++;
      $display("FAIL reset: in_ready=%b out_valid=%b dout=%h idx=%0d done=%b err=%b, want all 0",
               in_ready, out_valid, dout, out_index, poly_done, err_range);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
  endtask

  task automatic test_basic();
    logic [7:0] exp_b[3] = '{8'h23, 8'h61, 8'h45};
    din_1 = 16'h0123; din_2 = 16'h0456; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL basic_in_ready_empty: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      nvec++;
      if (out_valid !== 1'b1 || dout !== exp_b[k] || out_index !== 16'(k) || in_ready !== (k == 2)) begin
        nerr++;
        $display("FAIL basic_byte%0d: valid=%b dout=%h idx=%0d in_ready=%b, want 1 %h %0d %b",
                 k, out_valid, dout, out_index, in_ready, exp_b[k], k, k == 2);
      end
      tick();
    end
    nvec++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL basic_idle: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int base;
    base = m_idx;
    din_1 = 16'h0123; din_2 = 16'h0456; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      nvec++;
      if (dout !== 8'h61 || out_index !== 16'(base + 1) || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        nerr++;
        $display("FAIL stall%0d: dout=%h idx=%0d in_ready=%b valid=%b, want 61 %0d 0 1",
                 k, dout, out_index, in_ready, out_valid, base + 1);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    #1;
    nvec++;
    if (dout !== 8'h45 || out_index !== 16'(base + 2)) begin
      nerr++;
      $display("FAIL stall_resume: dout=%h idx=%0d, want 45 %0d", dout, out_index, base + 2);
    end
    tick();
  endtask

  task automatic test_canon();
    logic [7:0] exp_b[3] = '{8'h00, 8'h0D, 8'h00};
    din_1 = 16'hFFFF; din_2 = 16'hF2FF; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      nvec++;
      if (dout !== exp_b[k] || err_range !== 1'b0) begin
        nerr++;
        $display("FAIL canon_byte%0d: dout=%h err=%b, want %h 0", k, dout, err_range, exp_b[k]);
      end
      tick();
    end
  endtask

  task automatic test_range();
    din_1 = 16'h0D01; din_2 = 16'h0000; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    din_1 = 16'h0005; din_2 = 16'h0007;
    #1;
    nvec++;
    if (dout !== 8'h01 || err_range !== 1'b1) begin
      nerr++;
      $display("FAIL range_first: dout=%h err=%b, want 01 1", dout, err_range);
    end
    for (int k = 0; k < 9; k++) begin
      if (k == 5) in_valid = 1'b0;
      tick();
      nvec++;
      if (err_range !== 1'b1 || dout !== 8'(exp_dout())) begin
        nerr++;
        $display("FAIL range_sticky%0d: err=%b dout=%h, want 1 %h", k, err_range, dout, 8'(exp_dout()));
      end
    end
  endtask

  task automatic test_reset_mid();
    din_1 = 16'h0ABC; din_2 = 16'h0123; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || out_index !== 16'd0 || in_ready !== 1'b0 || err_range !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid: valid=%b idx=%0d in_ready=%b err=%b, want 0 0 0 0",
               out_valid, out_index, in_ready, err_range);
    end
    do_reset();
    set = 1'b0; in_valid = 1'b1; din_1 = 16'h0321; din_2 = 16'h0654;
    for (int k = 0; k < 3; k++) begin
      #1;
      nvec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || dout !== 8'h00) begin
        nerr++;
        $display("FAIL frozen%0d: in_ready=%b valid=%b dout=%h, want 0 0 00", k, in_ready, out_valid, dout);
      end
      tick();
    end
    set = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL resume_ready: in_ready=%b valid=%b, want 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    #1;
    nvec++;
    if (dout !== 8'h21 || out_index !== 16'd0 || out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL resume_byte0: dout=%h idx=%0d valid=%b, want 21 0 1", dout, out_index, out_valid);
    end
    repeat (3) tick();
  endtask

  task automatic test_stream();
    int pairs = 0, dones = 0, idle = 0;
    do_reset();
    set = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 395; cyc++) begin
      in_valid = (pairs < 129);
      din_1 = rand_coef(); din_2 = rand_coef();
      #1;
      nvec++;
      if (in_ready !== exp_in_ready() || out_valid !== exp_out_valid() || dout !== 8'(exp_dout()) ||
          out_index !== 16'(m_idx) || poly_done !== 1'(m_done) || err_range !== 1'(m_err)) begin
        nerr++;
        $display("FAIL stream%0d: rdy=%b v=%b d=%h i=%0d pd=%b e=%b, want %b %b %h %0d %b %b",
                 cyc, in_ready, out_valid, dout, out_index, poly_done, err_range, exp_in_ready(),
                 exp_out_valid(), 8'(exp_dout()), m_idx, 1'(m_done), 1'(m_err));
      end
      if (poly_done === 1'b1) dones++;
      if (cyc > 0 && cyc <= 387 && out_valid !== 1'b1) idle++;
      if (in_valid && in_ready) pairs++;
      tick();
    end
    nvec++;
    if (dones != 1 || idle != 0 || pairs != 129) begin
      nerr++;
      $display("FAIL stream_summary: dones=%0d idle=%0d pairs=%0d, want 1 0 129", dones, idle, pairs);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      set = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      din_1 = rand_coef(); din_2 = rand_coef();
      #1;
      nvec++;
      if (in_ready !== exp_in_ready() || out_valid !== exp_out_valid() || dout !== 8'(exp_dout()) ||
          out_index !== 16'(m_idx) || poly_done !== 1'(m_done) || err_range !== 1'(m_err)) begin
        nerr++;
        $display("FAIL random%0d: rdy=%b v=%b d=%h i=%0d pd=%b e=%b, want %b %b %h %0d %b %b",
                 cyc, in_ready, out_valid, dout, out_index, poly_done, err_range, exp_in_ready(),
                 exp_out_valid(), 8'(exp_dout()), m_idx, 1'(m_done), 1'(m_err));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_canon();
    test_range();
    test_reset_mid();
    test_stream();
    do_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
